vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameter SYNC_POL, default 0, meaning the sync asserted level (0 = active-low, as driven by the team's VGA timing generator).
REQ-002 SHALL have parameter LOCK_FRAMES, default 1, meaning the number of consecutive matching frames required after the measure frame before lock.
REQ-003 sys_clk  input  1  pixel clock; one pixel per clock.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 hsync, vsync  input  1 each  sync from the timing source, same clock domain.
REQ-006 nblank  input  1  high during visible pixels.
REQ-007 x_pos, y_pos  output  10 each  recovered active-area coordinates.
REQ-008 active  output  1  registered nblank, aligned with x_pos/y_pos.
REQ-009 h_total, v_total  output  11 each  measured clocks per line and lines per frame.
REQ-010 h_active, v_active  output  10 each  measured visible pixels per line and visible lines per frame.
REQ-011 frame_start  output  1  one-clock pulse on each vsync assertion edge.
REQ-012 locked  output  1  high while timing is stable.
REQ-013 timing_err  output  1  one-clock pulse on a mismatch or timeout.

Function
REQ-014 SHALL register hsync, vsync and nblank once, then detect assertion edges (SYNC_POL-adjusted); every output has a fixed latency of 2 clocks from the input pins.
REQ-015 SHALL run an 11-bit pixel counter that is cleared on each hsync assertion edge; the pre-clear value plus 1 is the line length.
REQ-016 SHALL run an 11-bit line counter that increments on each hsync edge and is cleared on each vsync edge; a coincident hsync edge counts as line 0.
REQ-017 x_pos: cleared on the nblank rise, incremented on every active clock, held while inactive.
REQ-018 y_pos: cleared on the vsync edge, incremented on each nblank fall; it saturates at 1023.
REQ-019 The line's visible pixel count SHALL be captured on the nblank fall.
REQ-020 The frame's visible line count SHALL be captured on the vsync edge.
REQ-021 The FSM SHALL have four states: SEARCH, MEASURE, VERIFY, LOCKED.
REQ-022 SEARCH: waits for the first vsync edge, then goes to MEASURE.
REQ-023 MEASURE: on the next vsync edge, latches h_total, v_total, h_active and v_active as the reference, then goes to VERIFY.
REQ-024 VERIFY: on each vsync edge, compares the frame's values to the reference.
REQ-025 VERIFY, match: after LOCK_FRAMES matching frames, goes to LOCKED.
REQ-026 VERIFY, mismatch: pulses timing_err, re-latches the reference and stays in VERIFY.
REQ-027 LOCKED: a mismatch at a vsync edge, or any line whose length differs from h_total, pulses timing_err, clears locked and goes to MEASURE.
REQ-028 locked SHALL be high only in LOCKED, asserted on the clock of the FSM transition.
REQ-029 Timeout: if the pixel counter reaches 2047 or the line counter reaches 2047, the block SHALL pulse timing_err and go to SEARCH from any state; the counters saturate and do not wrap.
REQ-030 If a line mismatch and a frame mismatch occur on the same clock, timing_err SHALL be a single pulse.

Reset
REQ-031 On reset, all counters, x_pos, y_pos, the totals and the reference SHALL be 0; active, frame_start, locked and timing_err SHALL be 0; the FSM SHALL be in SEARCH.
REQ-032 Reset mid-frame SHALL discard partial measurements; the block re-locks only after a full SEARCH/MEASURE/VERIFY sequence.

Structure
REQ-033 Shared package vga_pkg SHALL hold the FSM state enum, the counter widths (11/10) and the 640x480 constants: 800/525 total, 640/480 active.
REQ-034 Sub-module vga_edge_det SHALL implement the input register, polarity adjust and assertion-edge pulse; it is instantiated three times.

Verification
REQ-035 Drive the team's VGA generator (640x480, active-low sync) -> h_total=800, v_total=525, h_active=640, v_active=480; locked rises at the third vsync edge after reset.
REQ-036 Locked stream; lengthen one line to 801 clocks -> one timing_err pulse, locked=0 that line, re-lock two frames later.
REQ-037 Stop hsync after lock -> timing_err 2047 clocks after the last edge, FSM returns to SEARCH, locked=0.
REQ-038 Mid-visible-line check -> at the 100th active pixel of the 10th visible line, x_pos=99 and y_pos=9 with active=1.
REQ-039 Assert reset mid-frame while locked -> all outputs 0 the next clock; locked reasserts only after three vsync edges.
REQ-040 Set SYNC_POL=1 with inverted syncs -> the same totals as REQ-035; frame_start pulses once per 420000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sync receiver: counter widths, FSM
// states, the measured-timing record and the nominal 640x480 figures.
package vga_pkg;

  localparam int CNT_W = 11;
  localparam int POS_W = 10;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
  localparam logic [POS_W-1:0] POS_MAX  = '1;

  localparam int H_TOTAL_640  = 800;
  localparam int V_TOTAL_480  = 525;
  localparam int H_ACTIVE_640 = 640;
  localparam int V_ACTIVE_480 = 480;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } vga_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] v_total;
    logic [POS_W-1:0] h_active;
    logic [POS_W-1:0] v_active;
  } vga_timing_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [POS_W-1:0] sat_inc_pos(input logic [POS_W-1:0] v);
    return (v == POS_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Input register with polarity adjust; flags the assertion and release edges
// of the registered, polarity-normalised level.
module vga_edge_det #(
  parameter bit ACTIVE_LVL = 1'b1
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic lvl_q;
  logic lvl_qq;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      lvl_q  <= 1'b0;
      lvl_qq <= 1'b0;
    end else begin
      lvl_q  <= (pin == ACTIVE_LVL);
      lvl_qq <= lvl_q;
    end
  end

  assign level = lvl_q;
  assign rise  = lvl_q & ~lvl_qq;
  assign fall  = ~lvl_q & lvl_qq;

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers pixel coordinates and line/frame timing from a hsync/vsync/nblank
// stream, and tracks whether that timing is stable (lock) or broken.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             nblank,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [POS_W-1:0] h_active,
  output logic [POS_W-1:0] v_active,
  output logic             frame_start,
  output logic             locked,
  output logic             timing_err
);

  logic hs_edge, vs_edge, nb_lvl, nb_rise, nb_fall;
  logic unused_hs_level, unused_hs_fall, unused_vs_level, unused_vs_fall;

  vga_edge_det #(.ACTIVE_LVL(SYNC_POL)) u_hs_det (
    .sys_clk(sys_clk), .reset(reset), .pin(hsync),
    .level(unused_hs_level), .rise(hs_edge), .fall(unused_hs_fall)
  );

  vga_edge_det #(.ACTIVE_LVL(SYNC_POL)) u_vs_det (
    .sys_clk(sys_clk), .reset(reset), .pin(vsync),
    .level(unused_vs_level), .rise(vs_edge), .fall(unused_vs_fall)
  );

  vga_edge_det #(.ACTIVE_LVL(1'b1)) u_nb_det (
    .sys_clk(sys_clk), .reset(reset), .pin(nblank),
    .level(nb_lvl), .rise(nb_rise), .fall(nb_fall)
  );

  logic [CNT_W-1:0] pix_cnt, line_cnt, line_len, line_len_q;
  logic [POS_W-1:0] vis_len, vis_pix_q;

  assign line_len = sat_inc_cnt(pix_cnt);
  assign vis_len  = sat_inc_pos(x_pos);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_len_q  <= '0;
      vis_pix_q   <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_cnt <= hs_edge ? '0 : sat_inc_cnt(pix_cnt);
      // A vsync edge coinciding with a hsync edge makes that line line 0.
      if (vs_edge)      line_cnt <= '0;
      else if (hs_edge) line_cnt <= sat_inc_cnt(line_cnt);
      if (hs_edge) line_len_q <= line_len;
      if (nb_fall) vis_pix_q  <= vis_len;
      if (nb_rise)     x_pos <= '0;
      else if (nb_lvl) x_pos <= sat_inc_pos(x_pos);
      if (vs_edge)      y_pos <= '0;
      else if (nb_fall) y_pos <= sat_inc_pos(y_pos);
      active      <= nb_lvl;
      frame_start <= vs_edge;
    end
  end

  // Frame figures as seen at this clock, folding in any edge landing now.
  vga_timing_t cur, ref_q;
  always_comb begin
    cur.h_total  = hs_edge ? line_len : line_len_q;
    cur.v_total  = hs_edge ? sat_inc_cnt(line_cnt) : line_cnt;
    cur.h_active = nb_fall ? vis_len : vis_pix_q;
    cur.v_active = nb_fall ? sat_inc_pos(y_pos) : y_pos;
  end

  logic timeout, line_bad, frame_bad;
  assign timeout   = (!hs_edge && pix_cnt == CNT_LAST) ||
                     (hs_edge && !vs_edge && line_cnt == CNT_LAST);
  assign line_bad  = hs_edge && (line_len != ref_q.h_total);
  assign frame_bad = (cur != ref_q);

  vga_state_e  state, state_next;
  logic [31:0] match_cnt, match_cnt_next;
  logic        latch_ref, err_next;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    latch_ref      = 1'b0;
    err_next       = 1'b0;
    if (timeout) begin
      state_next     = SEARCH;
      match_cnt_next = '0;
      err_next       = 1'b1;
    end else begin
      case (state)
        SEARCH: if (vs_edge) state_next = MEASURE;
        MEASURE: if (vs_edge) begin
          latch_ref      = 1'b1;
          match_cnt_next = '0;
          state_next     = VERIFY;
        end
        VERIFY: if (vs_edge) begin
          if (frame_bad) begin
            err_next       = 1'b1;
            latch_ref      = 1'b1;
            match_cnt_next = '0;
          end else if (match_cnt + 32'd1 >= LOCK_FRAMES) begin
            match_cnt_next = '0;
            state_next     = LOCKED;
          end else begin
            match_cnt_next = match_cnt + 32'd1;
          end
        end
        LOCKED: if ((vs_edge && frame_bad) || line_bad) begin
          err_next   = 1'b1;
          state_next = MEASURE;
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      ref_q      <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_next;
      match_cnt  <= match_cnt_next;
      if (latch_ref) ref_q <= cur;
      locked     <= (state_next == LOCKED);
      timing_err <= err_next;
    end
  end

  assign h_total  = ref_q.h_total;
  assign v_total  = ref_q.v_total;
  assign h_active = ref_q.h_active;
  assign v_active = ref_q.v_active;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench: a scaled-down VGA generator (160x24 total, 128x16 visible)
// drives an active-low instance and an active-high instance of the receiver.
module tb_vga_sync_rx;
  import vga_pkg::*;

  localparam int H_TOT = 160, H_ACT = 128, HS_S = 136, HS_L = 12;
  localparam int V_TOT = 24,  V_ACT = 16,  VS_S = 19,  VS_L = 2;
  localparam int FRAME = H_TOT * V_TOT;

  logic sys_clk = 1'b0;
  logic reset;
  logic hsync0, vsync0, hsync1, vsync1, nblank;

  logic [POS_W-1:0] x0, y0, ha0, va0, x1, y1, ha1, va1;
  logic [CNT_W-1:0] ht0, vt0, ht1, vt1;
  logic act0, fs0, lock0, err0, act1, fs1, lock1, err1;

  vga_sync_rx #(.SYNC_POL(1'b0), .LOCK_FRAMES(1)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .hsync(hsync0), .vsync(vsync0),
    .nblank(nblank), .x_pos(x0), .y_pos(y0), .active(act0),
    .h_total(ht0), .v_total(vt0), .h_active(ha0), .v_active(va0),
    .frame_start(fs0), .locked(lock0), .timing_err(err0)
  );

  vga_sync_rx #(.SYNC_POL(1'b1), .LOCK_FRAMES(1)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .hsync(hsync1), .vsync(vsync1),
    .nblank(nblank), .x_pos(x1), .y_pos(y1), .active(act1),
    .h_total(ht1), .v_total(vt1), .h_active(ha1), .v_active(va1),
    .frame_start(fs1), .locked(lock1), .timing_err(err1)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0;
  int gh = 0, gv = 0, long_v = -1;
  bit hs_stop = 1'b0;
  int cyc = 0, te0_cnt = 0, fs1_cnt = 0, fs1_gap = 0, fs1_last = 0;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (err0) te0_cnt <= te0_cnt + 1;
    if (fs1) begin
      fs1_cnt  <= fs1_cnt + 1;
      fs1_gap  <= cyc - fs1_last;
      fs1_last <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel, let the DUT clock it, then advance the generator.
  task automatic tick();
    logic hs_a, vs_a;
    int   len;
    hs_a   = (gh >= HS_S) && (gh < HS_S + HS_L) && !hs_stop;
    vs_a   = (gv >= VS_S) && (gv < VS_S + VS_L);
    hsync0 = ~hs_a;
    vsync0 = ~vs_a;
    hsync1 = hs_a;
    vsync1 = vs_a;
    nblank = (gh < H_ACT) && (gv < V_ACT);
    @(negedge sys_clk);
    len = (gv == long_v) ? H_TOT + 1 : H_TOT;
    gh++;
    if (gh >= len) begin
      if (gv == long_v) long_v = -1;
      gh = 0;
      gv = (gv + 1) % V_TOT;
    end
  endtask

  task automatic goto(input int v, input int h);
    int n = 0;
    while (!(gv == v && gh == h) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++;
      errors++;
      $error("FAIL goto_bound observed=%0d expected<%0d", n, 2 * FRAME);
    end
  endtask

  // Afterwards the registered outputs reflect pixel (v,h).
  task automatic observe(input int v, input int h);
    goto(v, h);
    tick();
    tick();
  endtask

  task automatic check_zero(input string p);
    check({p, "_x"},    32'(x0),    0);
    check({p, "_y"},    32'(y0),    0);
    check({p, "_act"},  32'(act0),  0);
    check({p, "_ht"},   32'(ht0),   0);
    check({p, "_vt"},   32'(vt0),   0);
    check({p, "_ha"},   32'(ha0),   0);
    check({p, "_va"},   32'(va0),   0);
    check({p, "_fs"},   32'(fs0),   0);
    check({p, "_lock"}, 32'(lock0), 0);
    check({p, "_err"},  32'(err0),  0);
  endtask

  initial begin
    int te_base;
    reset  = 1'b1;
    hsync0 = 1'b1; vsync0 = 1'b1; hsync1 = 1'b0; vsync1 = 1'b0; nblank = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    check_zero("rst");
    check("rst_lock1", 32'(lock1), 0);

    // Lock-up: MEASURE at edge 1, reference latched at edge 2, lock at edge 3.
    observe(VS_S, 0);
    check("e1_fs",   32'(fs0),   1);
    check("e1_lock", 32'(lock0), 0);
    observe(VS_S, 0);
    check("e2_lock", 32'(lock0), 0);
    check("e2_ht",   32'(ht0),   H_TOT);
    observe(VS_S, 0);
    check("e3_lock",  32'(lock0), 1);
    check("e3_ht",    32'(ht0),   H_TOT);
    check("e3_vt",    32'(vt0),   V_TOT);
    check("e3_ha",    32'(ha0),   H_ACT);
    check("e3_va",    32'(va0),   V_ACT);
    check("pol_lock", 32'(lock1), 1);
    check("pol_ht",   32'(ht1),   H_TOT);
    check("pol_vt",   32'(vt1),   V_TOT);
    check("pol_ha",   32'(ha1),   H_ACT);
    check("pol_va",   32'(va1),   V_ACT);

    // 100th active pixel of the 10th visible line.
    observe(9, 99);
    check("xy_x",     32'(x0),   99);
    check("xy_y",     32'(y0),   9);
    check("xy_act",   32'(act0), 1);
    check("xy_fs",    32'(fs0),  0);
    check("pol_fcnt", fs1_cnt,   3);
    check("pol_fgap", fs1_gap,   FRAME);

    // One line stretched by a clock while locked.
    te_base = te0_cnt;
    long_v  = 12;
    observe(13, 135);
    check("ll_pre_err",  32'(err0),  0);
    check("ll_pre_lock", 32'(lock0), 1);
    tick();
    check("ll_err",  32'(err0),  1);
    check("ll_lock", 32'(lock0), 0);
    tick();
    check("ll_err_end", 32'(err0), 0);
    observe(VS_S, 0);
    check("ll_e1_lock", 32'(lock0), 0);
    check("ll_e1_fs",   32'(fs0),   1);
    observe(VS_S, 0);
    check("ll_relock", 32'(lock0), 1);
    check("ll_pulses", te0_cnt - te_base, 1);

    // Reset in the middle of a locked frame.
    goto(5, 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("mid");
    observe(VS_S, 0);
    check("mid_e1_lock", 32'(lock0), 0);
    observe(VS_S, 0);
    check("mid_e2_lock", 32'(lock0), 0);
    observe(VS_S, 0);
    check("mid_e3_lock", 32'(lock0), 1);
    check("mid_e3_ht",   32'(ht0),   H_TOT);

    // hsync stops after the edge on line 3.
    goto(3, 136);
    tick();
    hs_stop = 1'b1;
    tick();
    check("to_t0_err",  32'(err0),  0);
    check("to_t0_lock", 32'(lock0), 1);
    repeat (2046) tick();
    check("to_early_err", 32'(err0), 0);
    tick();
    check("to_err",   32'(err0),       1);
    check("to_lock",  32'(lock0),      0);
    check("to_state", 32'(dut0.state), 32'(SEARCH));
    tick();
    check("to_err_end", 32'(err0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
